// File: rtl/ftdi_arb_pkg.sv
// Shared types and helpers for the FTDI transmit arbiter and its round-robin picker.
package ftdi_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      HDR   = 2'd1,
      BURST = 2'd2
   } arb_state_t;

   localparam logic [7:0] HDR_MAGIC = 8'hA5;

   // First requesting index at or after ptr, wrapping modulo n (n <= 8); 0 when nobody requests.
   function automatic logic [2:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr,
                                          input int unsigned n);
      logic [2:0]  pick;
      logic        found;
      logic        hit;
      int unsigned idx;
      pick  = 3'd0;
      found = 1'b0;
      for (int unsigned k = 0; k < 8; k++) begin
         idx   = 32'(ptr) + k;
         idx   = (idx >= n) ? idx - n : idx;
         hit   = (k < n) && !found && req[idx[2:0]];
         pick  = hit ? idx[2:0] : pick;
         found = found | hit;
      end
      return pick;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: request vector plus pointer gives the winning index.
module rr_arbiter
   import ftdi_arb_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [IW-1:0] idx,
   output logic          any
);

   logic [2:0] pick_s;

   assign pick_s = rr_pick(8'(req), 3'(ptr), N);
   assign idx    = IW'(pick_s);
   assign any    = |req;

endmodule

// File: rtl/ftdi_tx_arbiter.sv
// Round-robin packet arbiter in front of the ftdi_245fifo send stream.
// Define FTDI_TX_ARB_HDR_EN to prefix every burst with a one-word source header.
module ftdi_tx_arbiter
   import ftdi_arb_pkg::*;
#(
   parameter int NUM_SRC   = 4,
   parameter int DSIZE     = 4,
   parameter int MAX_BURST = 64
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [NUM_SRC-1:0]           s_tvalid,
   output logic [NUM_SRC-1:0]           s_tready,
   input  logic [NUM_SRC*DSIZE*8-1:0]   s_tdata,
   input  logic [NUM_SRC-1:0]           s_tlast,
   output logic                         m_tvalid,
   input  logic                         m_tready,
   output logic [DSIZE*8-1:0]           m_tdata,
   output logic [$clog2(NUM_SRC)-1:0]   grant_id,
   output logic                         busy
);

   localparam int DW = DSIZE * 8;
   localparam int IW = $clog2(NUM_SRC);
   localparam int CW = $clog2(MAX_BURST + 1);

   arb_state_t      state_r, state_nxt_s;
   logic [IW-1:0]   grant_r, rr_ptr_r, pick_s, grant_inc_s;
   logic [CW-1:0]   cnt_r;
   logic            any_req_s, accept_s, burst_end_s;
   logic [DW-1:0]   src_data_s [NUM_SRC];

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
      assign src_data_s[i] = s_tdata[i*DW +: DW];
   end

   rr_arbiter #(.N(NUM_SRC), .IW(IW)) u_rr (
      .req (s_tvalid),
      .ptr (rr_ptr_r),
      .idx (pick_s),
      .any (any_req_s)
   );

   // Modulo wrap so non-power-of-two source counts never select a missing source.
   assign grant_inc_s = (grant_r == IW'(NUM_SRC - 1)) ? '0 : grant_r + IW'(1);
   assign grant_id    = grant_r;
   assign busy        = (state_r != IDLE);

`ifdef FTDI_TX_ARB_HDR_EN
   logic [DW-1:0] hdr_word_s;
   if (DSIZE == 1) begin : g_hdr_narrow
      assign hdr_word_s = {5'b10100, 3'(grant_r)};
   end else begin : g_hdr_wide
      assign hdr_word_s = DW'({HDR_MAGIC, 8'(grant_r)}) << (DW - 16);
   end
`endif

   // Next-state decode and the data-path mux driven from the registered grant.
   always_comb begin
      state_nxt_s = state_r;
      m_tvalid    = 1'b0;
      m_tdata     = '0;
      s_tready    = '0;
      accept_s    = 1'b0;
      burst_end_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (any_req_s) begin
`ifdef FTDI_TX_ARB_HDR_EN
               state_nxt_s = HDR;
`else
               state_nxt_s = BURST;
`endif
            end else begin
               state_nxt_s = IDLE;
            end
         end
`ifdef FTDI_TX_ARB_HDR_EN
         HDR: begin
            m_tvalid = 1'b1;
            m_tdata  = hdr_word_s;
            if (m_tready) begin
               state_nxt_s = BURST;
            end else begin
               state_nxt_s = HDR;
            end
         end
`endif
         BURST: begin
            m_tvalid           = s_tvalid[grant_r];
            m_tdata            = src_data_s[grant_r];
            s_tready[grant_r]  = m_tready;
            accept_s           = s_tvalid[grant_r] & m_tready;
            burst_end_s        = accept_s & (s_tlast[grant_r] | (cnt_r == CW'(MAX_BURST - 1)));
            if (burst_end_s) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = BURST;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // State, grant, round-robin pointer and burst word counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r  <= IDLE;
         grant_r  <= '0;
         rr_ptr_r <= '0;
         cnt_r    <= '0;
      end else begin
         state_r <= state_nxt_s;
         if (state_r == IDLE && any_req_s) begin
            grant_r <= pick_s;
         end
         if (burst_end_s) begin
            rr_ptr_r <= grant_inc_s;
            cnt_r    <= '0;
         end else if (accept_s) begin
            cnt_r <= cnt_r + CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_ftdi_tx_arbiter.sv
// Randomised and directed bench for ftdi_tx_arbiter against a packet-level queue model.
module tb_ftdi_tx_arbiter;

   localparam int N  = 4;
   localparam int DS = 4;
   localparam int MB = 64;
   localparam int DW = DS * 8;
`ifdef FTDI_TX_ARB_HDR_EN
   localparam int HDR_EN = 1;
`else
   localparam int HDR_EN = 0;
`endif

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    s_tvalid, s_tready, s_tlast;
   logic [N*DW-1:0] s_tdata;
   logic            m_tvalid, m_tready;
   logic [DW-1:0]   m_tdata;
   logic [1:0]      grant_id;
   logic            busy;

   always #5 clk = ~clk;

   ftdi_tx_arbiter #(.NUM_SRC(N), .DSIZE(DS), .MAX_BURST(MB)) dut (
      .clk(clk), .rst_n(rst_n),
      .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tlast(s_tlast),
      .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
      .grant_id(grant_id), .busy(busy)
   );

   // source drivers and the independent model each keep their own copy of the packets
   logic [DW:0] drv_q [N][$];
   logic [DW:0] mdl_q [N][$];
   bit          en [N];
   bit          rdy;
   int          owner, sent, ptr, g_last;
   bit          hdr_ph;
   int          total = 0, bad = 0, cyc = 0, cyc0 = 0;
   int          xd[$], xc[$], xs[$], hd[$];
   bit          bl[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int pending();
      int s = 0;
      for (int i = 0; i < N; i++) s += mdl_q[i].size();
      return s;
   endfunction

   task automatic add_pkt(input int src, input int len, input int base);
      logic [DW:0] w;
      for (int k = 0; k < len; k++) begin
         w = {(k == len - 1), 32'(base + k)};
         drv_q[src].push_back(w);
         mdl_q[src].push_back(w);
      end
   endtask

   task automatic drive_inputs();
      for (int i = 0; i < N; i++) begin
         s_tvalid[i] = (drv_q[i].size() > 0) && en[i];
         s_tdata[i*DW +: DW] = (drv_q[i].size() > 0) ? drv_q[i][0][DW-1:0] : '0;
         s_tlast[i] = (drv_q[i].size() > 0) ? drv_q[i][0][DW] : 1'b0;
      end
      m_tready = rdy;
   endtask

   task automatic clear_logs();
      xd.delete(); xc.delete(); xs.delete(); hd.delete(); bl.delete();
      cyc0 = cyc;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      for (int i = 0; i < N; i++) begin
         drv_q[i].delete();
         mdl_q[i].delete();
      end
      owner = -1; sent = 0; ptr = 0; g_last = 0; hdr_ph = 1'b0;
      drive_inputs();
      #1;
      chk("rst_s_tready", s_tready, 0);
      chk("rst_m_tvalid", m_tvalid, 0);
      chk("rst_m_tdata", m_tdata, 0);
      chk("rst_grant_id", grant_id, 0);
      chk("rst_busy", busy, 0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // one clock: drive, compare against the model, then advance model and drivers
   task automatic cycle();
      bit           ev, found;
      logic [DW-1:0] ed;
      logic [N-1:0] er;
      logic [DW:0]  w;
      int           j;
      @(negedge clk);
      drive_inputs();
      #1;
      ev = 1'b0; ed = '0; er = '0;
      if (owner >= 0 && hdr_ph) begin
         ev = 1'b1;
         ed = {8'hA5, 8'(owner), 16'h0000};
      end else if (owner >= 0) begin
         ev = en[owner] && (mdl_q[owner].size() > 0);
         ed = ev ? mdl_q[owner][0][DW-1:0] : '0;
         er[owner] = rdy;
      end
      chk("m_tvalid", m_tvalid, ev);
      if (ev) chk("m_tdata", m_tdata, ed);
      chk("s_tready", s_tready, er);
      chk("busy", busy, owner >= 0);
      chk("grant_id", grant_id, g_last);
      if (m_tvalid && m_tready) begin
         if (hdr_ph) hd.push_back(m_tdata);
         else begin
            xd.push_back(m_tdata); xc.push_back(cyc); xs.push_back(grant_id);
         end
      end
      bl.push_back(busy);
      if (owner < 0) begin
         found = 1'b0;
         for (int k = 0; k < N; k++) begin
            j = (ptr + k) % N;
            if (!found && en[j] && mdl_q[j].size() > 0) begin
               found = 1'b1; owner = j;
            end
         end
         if (found) begin
            sent = 0; g_last = owner; hdr_ph = (HDR_EN != 0);
         end
      end else if (hdr_ph) begin
         if (rdy) hdr_ph = 1'b0;
      end else if (ev && rdy) begin
         w = mdl_q[owner].pop_front();
         sent++;
         if (w[DW] || sent == MB) begin
            ptr = (owner + 1) % N;
            owner = -1;
         end
      end
      for (int i = 0; i < N; i++)
         if (s_tvalid[i] && s_tready[i] && drv_q[i].size() > 0) void'(drv_q[i].pop_front());
      cyc++;
      @(posedge clk);
   endtask

   task automatic run_drain(input string nm, input int budget);
      int n = 0;
      while ((pending() > 0 || owner >= 0) && n < budget) begin
         cycle();
         n++;
      end
      chk({"drain_", nm}, pending() + ((owner >= 0) ? 1 : 0), 0);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int e2 [12] = '{'h100, 'h101, 'h102, 'h300, 'h301, 'h302,
                      'h110, 'h111, 'h112, 'h310, 'h311, 'h312};
      int rs[$], rl[$];
      int ers [6] = '{1, 2, 1, 2, 1, 2};
      int erl [6] = '{64, 4, 64, 4, 22, 4};
      int n;
      for (int i = 0; i < N; i++) en[i] = 1'b1;
      rdy = 1'b1;
      s_tvalid = '0; s_tdata = '0; s_tlast = '0; m_tready = 1'b0;
      do_reset();

      // single source, back-to-back words and one idle bubble between packets
      add_pkt(2, 5, 'h10);
      add_pkt(2, 2, 'h20);
      clear_logs();
      run_drain("single", 100);
      cycle();
      chk("t1_count", xd.size(), 7);
      for (int k = 0; k < 5; k++) begin
         chk("t1_data", xd[k], 'h10 + k);
         chk("t1_back2back", xc[k] - xc[0], k);
         chk("t1_grant", xs[k], 2);
      end
      chk("t1_latency", xc[0] - cyc0, 1 + HDR_EN);
      chk("t1_bubble", xc[5] - xc[4], 2 + HDR_EN);
      chk("t1_busy_after", bl[xc[4] - cyc0 + 1], 0);
      chk("t1_busy_end", bl[xc[6] - cyc0 + 1], 0);

      // two sources, strict round robin across two rounds
      do_reset();
      add_pkt(0, 3, 'h100); add_pkt(3, 3, 'h300);
      add_pkt(0, 3, 'h110); add_pkt(3, 3, 'h310);
      clear_logs();
      run_drain("rr", 200);
      chk("t2_count", xd.size(), 12);
      for (int k = 0; k < 12; k++) chk("t2_order", xd[k], e2[k]);

      // long packet split at MAX_BURST and interleaved with a second source
      do_reset();
      add_pkt(1, 150, 'h1000);
      for (int p = 0; p < 3; p++) add_pkt(2, 4, 'h2000 + 16 * p);
      clear_logs();
      run_drain("split", 1000);
      foreach (xs[k]) begin
         if (k == 0 || xs[k] != xs[k-1]) begin
            rs.push_back(xs[k]); rl.push_back(1);
         end else rl[rl.size()-1]++;
      end
      chk("t3_runs", rs.size(), 6);
      for (int k = 0; k < 6 && k < rs.size(); k++) begin
         chk("t3_run_src", rs[k], ers[k]);
         chk("t3_run_len", rl[k], erl[k]);
      end

      // sink toggling ready every cycle
      do_reset();
      add_pkt(0, 6, 'h40);
      clear_logs();
      n = 0;
      while ((pending() > 0 || owner >= 0) && n < 100) begin
         rdy = (n % 2) == 0;
         cycle();
         n++;
      end
      rdy = 1'b1;
      chk("t4_count", xd.size(), 6);
      for (int k = 0; k < 6 && k < xd.size(); k++) chk("t4_data", xd[k], 'h40 + k);

      // reset in the middle of a burst drops the packet and restarts from source 0
      do_reset();
      add_pkt(1, 2, 'h50);
      run_drain("pre_rst", 50);
      add_pkt(2, 10, 'h60);
      clear_logs();
      n = 0;
      while (xd.size() < 3 && n < 50) begin
         cycle();
         n++;
      end
      chk("t5_three_words", xd.size(), 3);
      do_reset();
      add_pkt(1, 2, 'h70); add_pkt(3, 2, 'h80);
      clear_logs();
      run_drain("post_rst", 50);
      chk("t5_count", xd.size(), 4);
      chk("t5_first_src", xs[0], 1);
      chk("t5_first_data", xd[0], 'h70);

`ifdef FTDI_TX_ARB_HDR_EN
      // header word held stable while the sink stalls
      do_reset();
      add_pkt(1, 2, 'h90);
      clear_logs();
      rdy = 1'b0;
      cycle();
      for (int k = 0; k < 3; k++) begin
         cycle();
         #1;
         chk("hdr_hold", m_tdata, 32'hA501_0000);
         chk("hdr_no_ready", s_tready, 0);
      end
      rdy = 1'b1;
      run_drain("hdr", 50);
      chk("hdr_word", hd[0], 32'hA501_0000);
      chk("hdr_d0", xd[0], 'h90);
      chk("hdr_d1", xd[1], 'h91);
`endif

      // randomised traffic with valid gaps and sink stalls
      do_reset();
      for (int s = 0; s < N; s++)
         for (int p = 0; p < 5; p++)
            add_pkt(s, $urandom_range(1, 90), (s << 12) | (p << 8));
      n = 0;
      while ((pending() > 0 || owner >= 0) && n < 20000) begin
         for (int i = 0; i < N; i++) en[i] = ($urandom % 5) != 0;
         rdy = ($urandom % 4) != 0;
         cycle();
         n++;
      end
      chk("random_drain", pending() + ((owner >= 0) ? 1 : 0), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ftdi_tx_arbiter.md
Name: ftdi_tx_arbiter

Overview:
- Round-robin packet arbiter that shares the single user send stream (itvalid/itready/itdata) of ftdi_245fifo between NUM_SRC requesters, e.g. a loopback path, a status reporter and a capture engine.
- Each grant lasts until the source's tlast is accepted or MAX_BURST words have passed, so no source can starve the others.
- Sits in the iclk domain, directly in front of ftdi_245fifo's INPUT side.

Parameters:
- NUM_SRC, 4, number of requesting sources (2..8).
- DSIZE, 4, data width in bytes per word; must match ftdi_245fifo INPUT_DSIZE.
- MAX_BURST, 64, maximum words per grant (1..65535).

Ports:
- clk  input  1  single clock, same as ftdi_245fifo iclk.
- rst_n  input  1  asynchronous active-low reset.
- s_tvalid  input  NUM_SRC  per-source word valid.
- s_tready  output  NUM_SRC  per-source word accepted.
- s_tdata  input  NUM_SRC*DSIZE*8  packed source data; source i occupies bits [i*DSIZE*8 +: DSIZE*8].
- s_tlast  input  NUM_SRC  per-source end of packet.
- m_tvalid  output  1  to ftdi_245fifo itvalid.
- m_tready  input  1  from ftdi_245fifo itready.
- m_tdata  output  DSIZE*8  to ftdi_245fifo itdata.
- grant_id  output  $clog2(NUM_SRC)  currently or last granted source.
- busy  output  1  high while the FSM is not in IDLE.

Behaviour:
- Reset values:
  - Outputs: s_tready=0, m_tvalid=0, m_tdata=0, grant_id=0, busy=0.
  - Internal: state=IDLE, rr pointer=0, burst counter=0.
- Handshake: valid/ready. A word transfers when valid&ready are high at a clk edge. m_tvalid never depends combinationally on m_tready.
- FSM states: IDLE, HDR (feature only), BURST.
- IDLE:
  - If any s_tvalid is high, pick the first requesting index at or after rr pointer, wrapping modulo NUM_SRC.
  - Register grant_id. Go to BURST (or HDR when the feature is enabled).
  - Decision latency is 1 cycle; no data moves in IDLE.
- BURST:
  - m_tvalid = s_tvalid[grant_id] and m_tdata = s_tdata[grant_id], as a combinational mux from the registered grant.
  - s_tready[grant_id] = m_tready; all other s_tready are 0.
  - The counter increments on each accepted word.
  - Burst end: accepted word has s_tlast=1, or the counter reaches MAX_BURST-1 on an accepted word.
  - On burst end: rr pointer <= grant_id+1 (wrapping), counter <= 0, state <= IDLE.
  - Stalls (s_tvalid low or m_tready low) hold the grant indefinitely; there is no timeout.
- Simultaneous requests: round-robin order is strict. With sources 0..3 all requesting continuously, grants go 0,1,2,3,0...
- A packet split by MAX_BURST resumes only when the round-robin pointer returns to that source. Sinks must tolerate interleaving at MAX_BURST boundaries.
- Single requester: it is re-granted after one IDLE bubble cycle, giving a throughput loss of 1 cycle per burst.
- Reset asserted mid-burst: all state clears immediately. The partial packet is dropped from the arbiter's view and no further words of it are forwarded.
- Width rules:
  - The counter is $clog2(MAX_BURST+1) bits.
  - grant_id increments modulo NUM_SRC; it is not a power-of-two wrap.

Optional Feature:
- Macro: FTDI_TX_ARB_HDR_EN.
- Enabled:
  - HDR state emits one header word before each burst: m_tdata = {8'hA5, 8'(grant_id), zeros}, MSB-aligned for DSIZE>=2.
  - For DSIZE=1 the header is {5'b10100, 3'(grant_id)}.
  - The header is held until m_tready, then the FSM moves to BURST. All s_tready are 0 during HDR.
  - busy is high in HDR.
- Disabled: the HDR state and its logic are absent; IDLE goes directly to BURST. Host demultiplexing is then by protocol only.

Decomposition:
- Package ftdi_arb_pkg holds:
  - the state enum typedef (IDLE, HDR, BURST);
  - localparam HDR_MAGIC=8'hA5;
  - a function rr_pick(req, ptr) that returns the next index.
- Sub-module rr_arbiter: the combinational round-robin picker (req vector, pointer -> index plus any-request flag), reusable for RX demux later.

Test Plan:
- Single source 2 sends a 5-word packet 0x10..0x14 (tlast on 0x14), m_tready=1 -> m_tdata shows 0x10..0x14 back to back, grant_id=2, busy falls the cycle after the last word, IDLE lasts 1 cycle.
- Sources 0 and 3 each request with 3-word packets -> order is src0 words then src3 words; a second round starts with src0 (pointer wrapped 3->0).
- Source 1 sends a 150-word packet, MAX_BURST=64 -> bursts of 64, 64 and 22 words. If source 2 is also pending, its packet is interleaved after each 64-word chunk.
- m_tready toggles 1,0,1,0 during a burst -> no word is lost or duplicated, s_tready mirrors m_tready only for the granted source, and m_tdata stays stable while stalled.
- rst_n pulled low for 1 cycle after the 3rd word of a 10-word burst -> outputs go to reset values immediately, and the next grant follows fresh round-robin from 0.
- FTDI_TX_ARB_HDR_EN defined, source 1 sends a 2-word packet, DSIZE=4 -> 0xA5010000 then the 2 data words. Holding m_tready=0 for 3 cycles during HDR keeps the header stable.
